// File: rtl/shared_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data access.
// Optional mem_ready watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access in flight; arbitrate between data and fetch requests
// DATA  | data access: issue cycle, then mem_req held until mem_ready
// INST  | fetch access: issue cycle, then mem_req held until mem_ready
// RESP  | one-cycle done pulse; stale requests are not re-granted here
module shared_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              freeze_if,
    output logic              freeze_pipe,
    output logic              bus_error
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] starve_cnt;
    logic            owner_data;
    logic            lat_we;
    logic            busy;
    logic            grant_data;
    logic            grant_inst;
    logic            issue;
    logic            complete;
    logic            abort;

    assign busy       = (state == DATA) || (state == INST);
    assign grant_data = (state == IDLE) && dm_req && ((starve_cnt < STARVE_MAX) || !if_req);
    assign grant_inst = (state == IDLE) && if_req && !grant_data;
    assign issue      = busy && !mem_req;
    // mem_ready only counts once the bus request is actually visible to memory
    assign complete   = busy && mem_req && mem_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(TIMEOUT_CYCLES - 1);

    logic [WC_W-1:0] wait_cnt;
    logic            err_flag;

    assign abort = busy && mem_req && !mem_ready && (wait_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
        end else if (grant_data || grant_inst) begin
            wait_cnt <= WAIT_LOAD;
            err_flag <= 1'b0;
        end else if (abort) begin
            err_flag <= 1'b1;
        end else if (busy && mem_req && !mem_ready) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign bus_error = (state == RESP) && err_flag;
`else
    assign abort     = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_data) begin
                    state_nxt = DATA;
                end else if (grant_inst) begin
                    state_nxt = INST;
                end
            end
            DATA, INST: begin
                if (complete || abort) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            owner_data <= 1'b0;
            lat_we     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if (grant_data || grant_inst) begin
                owner_data <= grant_data;
                lat_we     <= grant_data && dm_we;
                mem_addr   <= grant_data ? dm_addr : if_addr;
                if (grant_data) begin
                    mem_wdata <= dm_wdata;
                end
            end

            if (grant_data && if_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_inst) begin
                starve_cnt <= '0;
            end

            if (issue) begin
                mem_req <= 1'b1;
                mem_we  <= lat_we;
            end else if (complete || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end

            if (complete && !lat_we) begin
                if (owner_data) begin
                    dm_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_done     = (state == RESP) && !owner_data;
    assign dm_done     = (state == RESP) && owner_data;
    assign freeze_pipe = dm_req && !dm_done;
    assign freeze_if   = (if_req && !if_done) || freeze_pipe;

endmodule
